// File: rtl/uart_rx.sv
// 8N1 serial receiver: synchronises the raw line, samples each bit at its centre,
// emits a one-cycle byte strobe on a good stop bit and a one-cycle error strobe on a bad one.
module uart_rx #(
  parameter int unsigned CLK_FREQ = 50000000,
  parameter int unsigned BAUD     = 115200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] uart_data,
  output logic       uart_valid,
  output logic       frame_error,
  output logic       rx_busy
);

  localparam int unsigned ClksPerBit = CLK_FREQ / BAUD;
  localparam int unsigned Half       = ClksPerBit / 2;
  localparam int unsigned CntW       = $clog2(ClksPerBit);

  localparam logic [CntW-1:0] CntBitEnd  = CntW'(ClksPerBit - 1);
  localparam logic [CntW-1:0] CntHalfEnd = CntW'(Half - 1);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StStop,
    StRecover
  } state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]      bit_idx_q, bit_idx_d;
  logic [7:0]      shreg_q, shreg_d;
  logic [7:0]      data_q, data_d;
  logic            valid_q, valid_d;
  logic            ferr_q, ferr_d;
  logic            busy_q, busy_d;
  logic [1:0]      sync_q;
  logic            rx_s;

  // Line idles high, so the synchroniser resets to 1 to avoid a false start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], rx};
    end
  end

  assign rx_s = sync_q[1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shreg_q   <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shreg_q   <= shreg_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      ferr_q    <= ferr_d;
      busy_q    <= busy_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    shreg_d   = shreg_q;
    data_d    = data_q;
    valid_d   = 1'b0;
    ferr_d    = 1'b0;

    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (!rx_s) begin
          state_d = StStart;
        end
      end

      StStart: begin
        cnt_d = cnt_q + 1'b1;
        // Mid-start re-check rejects glitches shorter than half a bit.
        if (cnt_q == CntHalfEnd) begin
          cnt_d = '0;
          if (!rx_s) begin
            state_d   = StData;
            bit_idx_d = '0;
          end else begin
            state_d = StIdle;
          end
        end
      end

      StData: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CntBitEnd) begin
          cnt_d     = '0;
          shreg_d   = {rx_s, shreg_q[7:1]};
          bit_idx_d = bit_idx_q + 1'b1;
          if (bit_idx_q == 3'd7) begin
            state_d = StStop;
          end
        end
      end

      StStop: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CntBitEnd) begin
          cnt_d = '0;
          if (rx_s) begin
            data_d  = shreg_q;
            valid_d = 1'b1;
            state_d = StIdle;
          end else begin
            ferr_d  = 1'b1;
            state_d = StRecover;
          end
        end
      end

      StRecover: begin
        cnt_d = '0;
        // Wait out a break so a held-low line flags only once.
        if (rx_s) begin
          state_d = StIdle;
        end
      end

      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase

    busy_d = (state_d != StIdle);
  end

  assign uart_data   = data_q;
  assign uart_valid  = valid_q;
  assign frame_error = ferr_q;
  assign rx_busy     = busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed scenarios plus random frames, compared against
// an event-level model (byte/error and the cycle each strobe must appear in).
module tb_uart_rx;

  localparam int unsigned Cpb = 16;
  // Two synchroniser flops, one cycle to leave IDLE, then HALF + 9 bit periods to the stop sample.
  localparam int Latency = 3 + 8 + 9 * 16;

  typedef struct packed {
    logic       is_err;
    logic [7:0] data;
    int         cyc;
  } ev_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx  = 1'b1;
  logic [7:0] uart_data;
  logic       uart_valid;
  logic       frame_error;
  logic       rx_busy;

  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  ev_t  got_q[$];
  ev_t  exp_q[$];
  logic [7:0] last_good = 8'h00;
  logic [7:0] prev_data = 8'h00;

  uart_rx #(
    .CLK_FREQ(16),
    .BAUD    (1)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .rx         (rx),
    .uart_data  (uart_data),
    .uart_valid (uart_valid),
    .frame_error(frame_error),
    .rx_busy    (rx_busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Strobe monitor; every strobe becomes an event for comparison with the model.
  always @(negedge clk) begin
    if (rst) begin
      prev_data = uart_data;
    end else begin
      if (uart_valid || frame_error) begin
        check("strobe_exclusive", {63'b0, uart_valid & frame_error}, 64'd0);
        got_q.push_back('{is_err: frame_error, data: uart_data, cyc: cyc});
      end
      if (uart_data !== prev_data) check("data_change_needs_valid", {63'b0, uart_valid}, 64'd1);
      prev_data = uart_data;
    end
  end

  // Drive the line for n cycles; always returns 1 time unit after a rising edge.
  task automatic hold(input logic v, input int n);
    rx = v;
    if (n > 0) begin
      repeat (n) @(posedge clk);
      #1;
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_ok);
    int n;
    n = cyc;
    hold(1'b0, Cpb);
    for (int i = 0; i < 8; i++) hold(b[i], Cpb);
    hold(stop_ok, Cpb);
    if (stop_ok) begin
      exp_q.push_back('{is_err: 1'b0, data: b, cyc: n + Latency});
      last_good = b;
    end else begin
      exp_q.push_back('{is_err: 1'b1, data: last_good, cyc: n + Latency});
    end
  endtask

  task automatic check_events(input string tag);
    check({tag, "_count"}, 64'(got_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      check({tag, "_event"}, 64'(got_q[i]), 64'(exp_q[i]));
    end
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_data"}, 64'(uart_data), 64'h00);
    check({tag, "_valid"}, {63'b0, uart_valid}, 64'd0);
    check({tag, "_ferr"}, {63'b0, frame_error}, 64'd0);
    check({tag, "_busy"}, {63'b0, rx_busy}, 64'd0);
  endtask

  initial begin
    int n;
    int bc;
    logic [7:0] b;
    logic ok;

    rst = 1'b1;
    rx  = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk);
    #1 rst = 1'b0;
    hold(1'b1, 5);

    // Single byte
    send_frame(8'h57, 1'b1);
    hold(1'b1, 4);
    check("single_busy_after", {63'b0, rx_busy}, 64'd0);
    check("single_data", 64'(uart_data), 64'h57);
    check_events("single");

    // Glitch: 5-cycle low pulse, busy must be high for exactly HALF cycles
    bc = 0;
    rx = 1'b0;
    for (int i = 0; i < 25; i++) begin
      if (i == 5) rx = 1'b1;
      @(negedge clk);
      if (rx_busy) bc++;
      @(posedge clk);
      #1;
    end
    check("glitch_busy_cycles", 64'(bc), 64'd8);
    check_events("glitch");

    // Bad stop bit
    send_frame(8'h41, 1'b0);
    check("recover_busy_line_low", {63'b0, rx_busy}, 64'd1);
    hold(1'b1, 5);
    check("recover_exit_busy", {63'b0, rx_busy}, 64'd0);
    check("bad_stop_data_kept", 64'(uart_data), 64'h57);
    check_events("bad_stop");

    // Break
    n = cyc;
    hold(1'b0, 400);
    exp_q.push_back('{is_err: 1'b1, data: last_good, cyc: n + Latency});
    hold(1'b1, 10);
    check("break_busy_after", {63'b0, rx_busy}, 64'd0);
    check_events("break");

    // Back-to-back frames, strobes 160 cycles apart
    send_frame(8'h77, 1'b1);
    send_frame(8'h61, 1'b1);
    send_frame(8'h64, 1'b1);
    hold(1'b1, 4);
    check_events("back_to_back");

    // Reset during bit 4 of 0x53
    b = 8'h53;
    hold(1'b0, Cpb);
    for (int i = 0; i < 4; i++) hold(b[i], Cpb);
    hold(b[4], 8);
    rst = 1'b1;
    rx  = 1'b1;
    last_good = 8'h00;
    @(negedge clk);
    check_reset_outputs("reset_mid");
    @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset_mid_held");
    @(posedge clk);
    #1 rst = 1'b0;
    hold(1'b1, 5);
    send_frame(8'h44, 1'b1);
    hold(1'b1, 4);
    check_events("reset_mid");

    // Random frames with occasional bad stop bits and random idle gaps
    for (int k = 0; k < 12; k++) begin
      b  = 8'($urandom);
      ok = ($urandom_range(3) != 0);
      send_frame(b, ok);
      if (!ok) hold(1'b1, 2 + int'($urandom_range(3)));
      else hold(1'b1, int'($urandom_range(20)));
    end
    hold(1'b1, 20);
    check_events("random");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
